// File: rtl/mem_line_arbiter.sv
// Two-client (I-cache / D-cache) line arbiter in front of a single memory adapter.
// Optional macro ARB_DCACHE_PRIO_EN: ties always grant D instead of round-robin.
module mem_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARB_DCACHE_PRIO_EN
  assign grant_d = d_req;
`else
  // Round-robin: on a tie, D wins unless D was the last client served.
  assign grant_d = d_req & (~i_req | ~last_d_q);
`endif

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          addr_d  = d_addr;
          // A combined read+write request is a write-back; the allocate comes later.
          wr_d    = d_write;
          rd_d    = d_read & ~d_write;
          wdata_d = d_wdata;
        end else if (i_req) begin
          state_d = SERVE_I;
          addr_d  = i_addr;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          wdata_d = '0;
        end
      end
      SERVE_I: begin
        if (m_resp) begin
          state_d  = IDLE;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          last_d_d = 1'b0;
        end
      end
      SERVE_D: begin
        if (m_resp) begin
          state_d  = IDLE;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          last_d_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Downstream request comes only from the latched transaction; address is line-aligned.
  assign m_addr  = {addr_q[ADDR_W-1:5], 5'd0};
  assign m_read  = rd_q;
  assign m_write = wr_q;
  assign m_wdata = wdata_q;
  assign busy    = (state_q != IDLE);

  assign i_resp  = (state_q == SERVE_I) & m_resp;
  assign d_resp  = (state_q == SERVE_D) & m_resp;
  assign i_rdata = i_resp ? m_rdata : '0;
  assign d_rdata = d_resp ? m_rdata : '0;

endmodule

// File: doc/mem_line_arbiter.md
MEM_LINE_ARBITER -- requirements
Module: mem_line_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width in bits.
REQ-002 Parameter LINE_W, default 256, cache-line width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Ports i_addr, input, ADDR_W; i_read, input, 1: I-cache line-read request.
REQ-006 Ports i_rdata, output, LINE_W; i_resp, output, 1: I-cache response data and 1-cycle done pulse.
REQ-007 Ports d_addr, input, ADDR_W; d_read, input, 1; d_write, input, 1; d_wdata, input, LINE_W: D-cache line request (allocate or write-back).
REQ-008 Ports d_rdata, output, LINE_W; d_resp, output, 1: D-cache response data and 1-cycle done pulse.
REQ-009 Ports m_addr, output, ADDR_W; m_read, output, 1; m_write, output, 1; m_wdata, output, LINE_W: single downstream request to the memory adapter.
REQ-010 Ports m_rdata, input, LINE_W; m_resp, input, 1: downstream response data and done pulse.
REQ-011 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement states IDLE, SERVE_I, SERVE_D.
REQ-013 In IDLE, with only I requesting (i_read), next state SHALL be SERVE_I; with only D requesting (d_read|d_write), next state SHALL be SERVE_D.
REQ-014 In IDLE, with both requesting, grant SHALL go to the client not granted last (round-robin); after reset the last-grant flag SHALL be I, so D wins the first tie.
REQ-015 On grant, the block SHALL latch the granted client's address, read/write and wdata into internal registers; m_* SHALL be driven only from these registers.
REQ-016 m_addr SHALL equal the latched address with bits [4:0] forced to zero.
REQ-017 If d_read and d_write are both high at grant, the block SHALL latch a write only (write-back before allocate).
REQ-018 In SERVE_x, m_read/m_write SHALL stay asserted, stable, until the cycle m_resp is sampled high.
REQ-019 When m_resp is high in SERVE_x, the block SHALL assert x_resp for exactly that one cycle, drive x_rdata = m_rdata combinationally, deassert m_read/m_write next cycle, update last-grant to x, and return to IDLE.
REQ-020 Grant latency: request seen in IDLE at edge N -> m_read/m_write high after edge N; a new grant SHALL NOT occur in the same cycle as a response (minimum one IDLE cycle between transactions).
REQ-021 m_resp while in IDLE SHALL be ignored; no resp output pulses.
REQ-022 Requests arriving or dropping while in SERVE_x SHALL NOT affect the transaction in progress.
REQ-023 i_resp and d_resp SHALL never be high in the same cycle.
REQ-024 i_rdata and d_rdata SHALL be zero when their respective resp is low.

Reset
REQ-025 On rst, state SHALL be IDLE, last-grant SHALL be I, latched registers zero; m_read, m_write, i_resp, d_resp, busy SHALL be 0; m_addr, m_wdata 0.
REQ-026 rst mid-transaction SHALL abort it immediately with no resp pulse; a later m_resp SHALL be ignored.

Configuration
REQ-027 Macro ARB_DCACHE_PRIO_EN: when defined, ties in IDLE SHALL always grant D (fixed priority), the last-grant flag unused; when undefined, REQ-014 round-robin applies.

Verification
REQ-028 After reset, i_read=1, i_addr=0x1000_0024 -> next cycle m_read=1, m_addr=0x1000_0020; m_resp with m_rdata=X -> i_resp=1, i_rdata=X same cycle, IDLE next.
REQ-029 i_read and d_read both high from reset -> D served first, then I; repeat tie -> D after I (round-robin); with ARB_DCACHE_PRIO_EN, D every time.
REQ-030 d_read=d_write=1, d_wdata=0xA5..A5 -> m_write=1, m_read=0, m_wdata=0xA5..A5; d_resp one cycle on m_resp.
REQ-031 Spurious m_resp in IDLE -> no i_resp/d_resp, state stays IDLE.
REQ-032 rst asserted mid SERVE_D -> m_write/m_read 0 asynchronously, busy 0, subsequent m_resp produces no d_resp.
REQ-033 Continuous requests from both for 100 transactions -> i_resp/d_resp never concurrent, grants alternate, m_* stable between grant and response.
